// File: rtl/dist_ram_arb_if.sv
// Requester, RAM-port and response bundle for dist_ram_arb.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface dist_ram_arb_if #(
  parameter int NUM_COL    = 16,
  parameter int COL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  r0_valid;
  logic                  r0_ready;
  logic [NUM_COL-1:0]    r0_wen;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_din;

  logic                  r1_valid;
  logic                  r1_ready;
  logic [NUM_COL-1:0]    r1_wen;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_din;

  logic [NUM_COL-1:0]    ram_wen;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic                  rsp_valid;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport slave (
    input  r0_valid, r0_wen, r0_addr, r0_din,
    input  r1_valid, r1_wen, r1_addr, r1_din,
    input  ram_dout,
    output r0_ready, r1_ready,
    output ram_wen, ram_addr, ram_din,
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output r0_valid, r0_wen, r0_addr, r0_din,
    output r1_valid, r1_wen, r1_addr, r1_din,
    output ram_dout,
    input  r0_ready, r1_ready,
    input  ram_wen, ram_addr, ram_din,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/dist_ram_arb.sv
// Two-requester round-robin arbiter in front of one registered-read distributed RAM port.
// Optional saturating per-requester grant counters: define DIST_RAM_ARB_STATS_EN.
module dist_ram_arb #(
  parameter int NUM_COL    = 16,
  parameter int COL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic          bram_clock_a,
  input  logic          rst,
  dist_ram_arb_if.slave bus
`ifdef DIST_RAM_ARB_STATS_EN
  ,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1
`endif
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  last_grant;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt_any;
  logic [NUM_COL-1:0]    sel_wen;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  logic [NUM_COL-1:0]    ram_wen_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_din_q;
  logic                  s1_valid;
  logic                  s1_id;
  logic                  s2_valid;
  logic                  s2_id;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
      if (last_grant) gnt0 = 1'b1;
      else            gnt1 = 1'b1;
    end else if (bus.r0_valid) begin
      gnt0 = 1'b1;
    end else if (bus.r1_valid) begin
      gnt1 = 1'b1;
    end
  end

  assign gnt_any = gnt0 | gnt1;

  always_comb begin
    sel_wen  = bus.r0_wen;
    sel_addr = bus.r0_addr;
    sel_din  = bus.r0_din;
    if (gnt1) begin
      sel_wen  = bus.r1_wen;
      sel_addr = bus.r1_addr;
      sel_din  = bus.r1_din;
    end
  end

  // Async clear of ram_wen also kills a write that is mid-flight when reset hits.
  always_ff @(posedge bram_clock_a or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      ram_wen_q  <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s2_valid   <= 1'b0;
      s2_id      <= 1'b0;
    end else begin
      if (gnt_any) begin
        last_grant <= gnt1;
        ram_wen_q  <= sel_wen;
        ram_addr_q <= sel_addr;
        ram_din_q  <= sel_din;
      end else begin
        ram_wen_q  <= '0;
      end
      s1_valid <= gnt_any && (sel_wen == '0);
      s1_id    <= gnt1;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

`ifdef DIST_RAM_ARB_STATS_EN
  always_ff @(posedge bram_clock_a or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (gnt0 && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (gnt1 && (grant_cnt1 != 16'hFFFF)) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

  assign bus.r0_ready  = gnt0;
  assign bus.r1_ready  = gnt1;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_data  = bus.ram_dout;
endmodule

// File: tb/tb_dist_ram_arb.sv
// Directed self-checking bench for dist_ram_arb with a registered-read RAM model.
// Counter saturation is exercised only when DIST_RAM_ARB_STATS_EN is defined.
module tb_dist_ram_arb;
  localparam int NUM_COL    = 16;
  localparam int COL_WIDTH  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DW         = NUM_COL * COL_WIDTH;

  localparam logic [NUM_COL-1:0] WEN_ALL = {NUM_COL{1'b1}};
  localparam logic [NUM_COL-1:0] WEN_RD  = '0;
  localparam logic [DW-1:0] PAT_A = {NUM_COL{32'hA5A5_A5A5}};
  localparam logic [DW-1:0] PAT_0 = {NUM_COL{32'h1234_5678}};
  localparam logic [DW-1:0] PAT_1 = {NUM_COL{32'hCAFE_0001}};

  logic bram_clock_a = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  dist_ram_arb_if #(.NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

`ifdef DIST_RAM_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  dist_ram_arb #(.NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .bram_clock_a (bram_clock_a),
    .rst          (rst),
    .bus          (bus)
`ifdef DIST_RAM_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1)
`endif
  );

  always #5 bram_clock_a = ~bram_clock_a;

  // Registered-read RAM with per-column write enables (read-before-write).
  logic [DW-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge bram_clock_a) begin
    for (int c = 0; c < NUM_COL; c++)
      if (bus.ram_wen[c])
        mem[bus.ram_addr][c*COL_WIDTH +: COL_WIDTH] <= bus.ram_din[c*COL_WIDTH +: COL_WIDTH];
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge bram_clock_a);
    #1;
  endtask

  task automatic idle();
    bus.r0_valid = 1'b0; bus.r0_wen = '0; bus.r0_addr = '0; bus.r0_din = '0;
    bus.r1_valid = 1'b0; bus.r1_wen = '0; bus.r1_addr = '0; bus.r1_din = '0;
  endtask

  task automatic drive0(input logic [NUM_COL-1:0] wen, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [DW-1:0] din);
    bus.r0_valid = 1'b1; bus.r0_wen = wen; bus.r0_addr = addr; bus.r0_din = din;
  endtask

  task automatic drive1(input logic [NUM_COL-1:0] wen, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [DW-1:0] din);
    bus.r1_valid = 1'b1; bus.r1_wen = wen; bus.r1_addr = addr; bus.r1_din = din;
  endtask

  logic [ADDR_WIDTH-1:0] rd_addr [3];
  logic [DW-1:0]         rd_data [3];

  initial begin
    idle();
    repeat (3) step();
    check("rst_ram_wen", bus.ram_wen, '0);
    check("rst_ram_addr", bus.ram_addr, '0);
    check("rst_ram_din", bus.ram_din, '0);
    check("rst_rsp_valid", bus.rsp_valid, '0);
    check("rst_rsp_id", bus.rsp_id, '0);
`ifdef DIST_RAM_ARB_STATS_EN
    check("rst_cnt0", grant_cnt0, '0);
    check("rst_cnt1", grant_cnt1, '0);
`endif
    rst = 1'b0;
    step();

    // r0 full-word write to address 3
    drive0(WEN_ALL, 5'd3, PAT_A);
    #1;
    check("wr_r0_ready", bus.r0_ready, 1'b1);
    check("wr_r1_ready", bus.r1_ready, 1'b0);
    step();
    idle();
    check("wr_ram_wen", bus.ram_wen, WEN_ALL);
    check("wr_ram_addr", bus.ram_addr, 5'd3);
    check("wr_ram_din", bus.ram_din, PAT_A);
    check("wr_no_rsp_t1", bus.rsp_valid, 1'b0);

    // r1 reads it back; response two cycles after the grant
    drive1(WEN_RD, 5'd3, '0);
    #1;
    check("rd_r1_ready", bus.r1_ready, 1'b1);
    check("rd_r0_ready", bus.r0_ready, 1'b0);
    step();
    idle();
    check("rd_ram_wen", bus.ram_wen, '0);
    check("rd_ram_addr", bus.ram_addr, 5'd3);
    check("rd_rsp_t1", bus.rsp_valid, 1'b0);
    step();
    check("rd_rsp_t2", bus.rsp_valid, 1'b1);
    check("rd_rsp_id", bus.rsp_id, 1'b1);
    check("rd_rsp_data", bus.rsp_data, PAT_A);
    step();
    check("rd_rsp_t3", bus.rsp_valid, 1'b0);

    // Contention for 4 cycles: last winner was r1, so r0,r1,r0,r1
    for (int i = 0; i < 4; i++) begin
      drive0(WEN_ALL, 5'd10, PAT_0);
      drive1(WEN_ALL, 5'd20, PAT_1);
      #1;
      check($sformatf("rr_ready0_%0d", i), bus.r0_ready, (i % 2 == 0));
      check($sformatf("rr_ready1_%0d", i), bus.r1_ready, (i % 2 == 1));
      step();
      check($sformatf("rr_addr_%0d", i), bus.ram_addr, (i % 2 == 0) ? 5'd10 : 5'd20);
      check($sformatf("rr_din_%0d", i), bus.ram_din, (i % 2 == 0) ? PAT_0 : PAT_1);
    end
    idle();
    step();
    check("rr_no_rsp", bus.rsp_valid, 1'b0);
    step();

    // Three back-to-back r0 reads return in order
    rd_addr[0] = 5'd10; rd_data[0] = PAT_0;
    rd_addr[1] = 5'd20; rd_data[1] = PAT_1;
    rd_addr[2] = 5'd3;  rd_data[2] = PAT_A;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b_valid_%0d", i), bus.rsp_valid, (i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) begin
        check($sformatf("b2b_id_%0d", i), bus.rsp_id, 1'b0);
        check($sformatf("b2b_data_%0d", i), bus.rsp_data, rd_data[i-2]);
      end
      if (i < 3) drive0(WEN_RD, rd_addr[i], '0);
      else       idle();
      step();
    end

    // Reset one cycle after a read grant discards the read
    drive0(WEN_RD, 5'd3, '0);
    step();
    idle();
    rst = 1'b1;
    #1;
    check("rrst_ram_addr", bus.ram_addr, '0);
    check("rrst_rsp_valid", bus.rsp_valid, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rrst_no_rsp_%0d", i), bus.rsp_valid, 1'b0);
      step();
    end

    // In-flight write is cut off by reset; r0 then wins contention again
    drive0(WEN_ALL, 5'd7, PAT_1);
    step();
    idle();
    check("wrst_wen_before", bus.ram_wen, WEN_ALL);
    rst = 1'b1;
    #1;
    check("wrst_wen_after", bus.ram_wen, '0);
    step();
    rst = 1'b0;
    step();
    drive0(WEN_RD, 5'd1, '0);
    drive1(WEN_RD, 5'd2, '0);
    #1;
    check("post_rst_ready0", bus.r0_ready, 1'b1);
    check("post_rst_ready1", bus.r1_ready, 1'b0);
    idle();

`ifdef DIST_RAM_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive0(WEN_RD, 5'd1, '0);
    repeat (3) step();
    check("cnt0_three", grant_cnt0, 16'd3);
    repeat (69997) step();
    check("cnt0_sat", grant_cnt0, 16'hFFFF);
    check("cnt1_zero", grant_cnt1, 16'd0);
    idle();
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dist_ram_arb.md
DIST_RAM_ARB -- requirements
Module: dist_ram_arb

Interface
REQ-001 Parameter NUM_COL, default 16, SHALL set the number of byte-enable columns per word.
REQ-002 Parameter COL_WIDTH, default 32, SHALL set the bits per column.
REQ-003 Parameter ADDR_WIDTH, default 5, SHALL set the RAM address bits, giving depth 2**ADDR_WIDTH.
REQ-004 clock  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 r0_valid/r1_valid  in  1  SHALL indicate that requester 0/1 presents a command.
REQ-007 r0_ready/r1_ready  out  1  SHALL indicate that the command is accepted this cycle.
REQ-008 r0_wen/r1_wen  in  NUM_COL  SHALL carry the column write enables; all-zero means read.
REQ-009 r0_addr/r1_addr  in  ADDR_WIDTH  SHALL carry the command address.
REQ-010 r0_din/r1_din  in  NUM_COL*COL_WIDTH  SHALL carry the write data.
REQ-011 ram_wen  out  NUM_COL  SHALL drive the RAM port write enables.
REQ-012 ram_addr  out  ADDR_WIDTH  SHALL drive the RAM port address.
REQ-013 ram_din  out  NUM_COL*COL_WIDTH  SHALL drive the RAM port write data.
REQ-014 ram_dout  in  NUM_COL*COL_WIDTH  SHALL receive the registered RAM read data.
REQ-015 rsp_valid  out  1  SHALL flag read data returning.
REQ-016 rsp_id  out  1  SHALL identify the requester that owns the returning read data.
REQ-017 rsp_data  out  NUM_COL*COL_WIDTH  SHALL carry the read data.
REQ-018 grant_cnt0/grant_cnt1  out  16  SHALL carry the per-requester grant counts (present only under REQ-033).

Function
REQ-019 Handshake: a command SHALL be accepted in any cycle where rN_valid and rN_ready are both 1; rN_ready SHALL be combinational and at most one rN_ready SHALL be 1 per cycle.
REQ-020 Arbitration, single requester valid: that requester SHALL be granted that cycle.
REQ-021 Arbitration, both valid: the requester other than last_grant SHALL be granted (round-robin), and last_grant SHALL update to the granted id.
REQ-022 Arbitration, neither valid: no requester SHALL be granted, and last_grant SHALL hold.
REQ-023 Granted command in cycle T: ram_wen/ram_addr/ram_din SHALL be registered and present in cycle T+1.
REQ-024 No grant in cycle T: ram_wen SHALL be all-zero in T+1, and ram_addr/ram_din SHALL hold their previous values.
REQ-025 Granted read (wen all-zero) in cycle T: rsp_valid SHALL be 1 in cycle T+2 with rsp_id equal to the granted id; latency is fixed at 2 cycles.
REQ-026 rsp_data SHALL equal ram_dout directly; rsp_data is defined only while rsp_valid=1.
REQ-027 Writes SHALL produce no response.
REQ-028 Back-to-back reads SHALL sustain one grant per cycle and one response per cycle, returned in grant order.
REQ-029 rsp_valid SHALL have no backpressure; requesters SHALL always accept responses.
REQ-030 Pipeline: a 2-stage valid/id shift register (s1, s2) SHALL track outstanding reads; s2 SHALL drive rsp_valid/rsp_id.

Reset
REQ-031 Asserting reset SHALL clear ram_wen, ram_addr, ram_din, rsp_valid, rsp_id, both pipeline stages and the counters to 0, and SHALL set last_grant to 1 so requester 0 wins the first contention.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads (no response after reset), and an in-flight write SHALL be suppressed because ram_wen clears asynchronously.

Configuration
REQ-033 Macro DIST_RAM_ARB_STATS_EN, when defined: grant_cnt0/grant_cnt1 SHALL exist and SHALL increment on each grant to requester 0/1, saturating at 16'hFFFF.
REQ-034 Macro DIST_RAM_ARB_STATS_EN, when undefined: grant_cnt0/grant_cnt1 SHALL be absent and no counter logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-035 Reset release, then r0 write addr 3, wen all-ones, din 0xA5.. -> ram_wen all-ones with ram_addr 3 next cycle; no rsp_valid.
REQ-036 r1 read addr 3 after REQ-035 -> rsp_valid=1, rsp_id=1 two cycles after the grant, with rsp_data equal to the written value.
REQ-037 r0 and r1 both valid for 4 cycles -> grants r0,r1,r0,r1; exactly one ready per cycle.
REQ-038 r0 reads issued on 3 consecutive cycles -> 3 consecutive rsp_valid cycles, in order.
REQ-039 Reset asserted one cycle after a read grant -> rsp_valid stays 0, and r0 wins the first contention after reset.
REQ-040 With DIST_RAM_ARB_STATS_EN defined, r0 held valid for 70000 cycles -> grant_cnt0 saturates at 0xFFFF and grant_cnt1 stays 0.
